// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state type and constants for pipe_stage_reg.
package pipe_pkg;
   typedef enum logic [1:0] {EMPTY, ONE, FULL} stage_state_e;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
endpackage

// File: rtl/pipe_stage_entry.sv
// pipe_stage_entry: load-enable register with asynchronous clear to a reset value.
module pipe_stage_entry #(
   parameter int           W   = 32,
   parameter logic [W-1:0] RST = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) r_q <= RST;
      else if (i_load) r_q <= i_d;
   assign o_q = r_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with 2-entry skid buffer and flush.
// Optional stall/bubble counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int              DATA_W   = 128,
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [31:0]       stat_stall,
   output logic [31:0]       stat_bubble
`endif
);
   localparam int W = PC_W + DATA_W;
   stage_state_e r_state, w_next;
   logic         r_out_valid, r_in_ready, w_accept, w_fire, w_load_main, w_load_skid;
   logic [W-1:0] w_main_d, w_main_q, w_skid_q;

   assign w_accept = in_valid && r_in_ready;
   assign w_fire   = r_out_valid && out_ready;
   assign w_main_d = (r_state == FULL) ? w_skid_q : {in_pc, in_data};

   always_comb begin
      w_next      = r_state;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
      if (flush) w_next = EMPTY;
      else case (r_state)
         EMPTY: if (w_accept) begin
            w_next      = ONE;
            w_load_main = 1'b1;
         end
         ONE: if (w_accept && w_fire) w_load_main = 1'b1;
         else if (w_accept) begin
            w_next      = FULL;
            w_load_skid = 1'b1;
         end
         else if (w_fire) w_next = EMPTY;
         FULL: if (w_fire) begin
            w_next      = ONE;
            w_load_main = 1'b1;
         end
         default: w_next = EMPTY;
      endcase
   end

   // Handshake outputs are registered copies of the next-state decode.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state     <= EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         r_state     <= w_next;
         r_out_valid <= (w_next != EMPTY);
         r_in_ready  <= (w_next != FULL);
      end

   pipe_stage_entry #(.W(W), .RST({RESET_PC, {DATA_W{1'b0}}})) u_main (
      .clk(clk), .reset(reset), .i_load(w_load_main), .i_d(w_main_d), .o_q(w_main_q)
   );
   pipe_stage_entry #(.W(W), .RST('0)) u_skid (
      .clk(clk), .reset(reset), .i_load(w_load_skid), .i_d({in_pc, in_data}), .o_q(w_skid_q)
   );

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_pc    = w_main_q[W-1:DATA_W];
   assign out_data  = r_out_valid ? w_main_q[DATA_W-1:0] : {DATA_W{1'b0}};

`ifdef PIPE_STAGE_STATS_EN
   logic [31:0] r_stall, r_bubble;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_stall  <= '0;
         r_bubble <= '0;
      end else begin
         if (r_out_valid && !out_ready && ~&r_stall) r_stall <= r_stall + 32'd1;
         if (!r_out_valid && ~&r_bubble) r_bubble <= r_bubble + 32'd1;
      end
   assign stat_stall  = r_stall;
   assign stat_bubble = r_bubble;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized scoreboard bench for pipe_stage_reg against a
// queue model of the beats held in the stage.
module tb_pipe_stage_reg;
   logic         clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic         in_ready, out_valid;
   logic [31:0]  in_pc = '0, out_pc;
   logic [127:0] in_data = '0, out_data;
`ifdef PIPE_STAGE_STATS_EN
   logic [31:0]  stat_stall, stat_bubble;
   int           m_stall = 0, m_bub = 0;
`endif

   typedef struct {logic [31:0] pc; logic [127:0] d;} beat_t;
   beat_t       q[$];
   logic [31:0] last_pc = 32'h3000;
   int          pass = 0, total = 0, fails = 0;

   pipe_stage_reg dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_data(out_data)
`ifdef PIPE_STAGE_STATS_EN
      , .stat_stall(stat_stall), .stat_bubble(stat_bubble)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act === exp) pass++;
      else begin
         fails++;
         if (fails <= 30) $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: compare DUT against the model, then apply the coming edge's events.
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         last_pc = 32'h3000;
`ifdef PIPE_STAGE_STATS_EN
         m_stall = 0;
         m_bub   = 0;
`endif
      end
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_pc", out_pc, q.size() != 0 ? q[0].pc : last_pc);
      chk("out_data", out_data, q.size() != 0 ? q[0].d : 128'(0));
`ifdef PIPE_STAGE_STATS_EN
      chk("stat_stall", stat_stall, m_stall);
      chk("stat_bubble", stat_bubble, m_bub);
`endif
      if (!reset) begin
         automatic bit fire   = (q.size() != 0) && out_ready;
         automatic bit accept = in_valid && (q.size() < 2);
`ifdef PIPE_STAGE_STATS_EN
         if (q.size() == 0) m_bub++;
         else if (!out_ready) m_stall++;
`endif
         if (flush) q.delete();
         else begin
            if (fire) void'(q.pop_front());
            if (accept) q.push_back('{in_pc, in_data});
         end
         if (q.size() != 0) last_pc = q[0].pc;
      end
   end

   task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl, input int n = 1);
      in_valid  = v;
      in_pc     = pc;
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = rdy;
      flush     = fl;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [31:0] pc;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_pc", out_pc, 32'h3000);
      chk("rst_valid", out_valid, 1'b0);
      // streaming
      drive(1, 32'h3000, 1, 0);
      drive(1, 32'h3004, 1, 0);
      chk("stream_pc1", out_pc, 32'h3004);
      drive(1, 32'h3008, 1, 0);
      chk("stream_pc2", {out_valid, out_pc}, {1'b1, 32'h3008});
      drive(0, 0, 1, 0);
      // stall and drain
      drive(1, 32'h3000, 0, 0);
      drive(1, 32'h3004, 0, 0);
      chk("stall_in_ready", in_ready, 1'b0);
      drive(0, 0, 1, 0);
      chk("drain_pc", out_pc, 32'h3004);
      drive(0, 0, 1, 0);
      chk("drain_ready", {in_ready, out_valid}, 2'b10);
      // flush while FULL with a beat offered
      drive(1, 32'h3010, 0, 0);
      drive(1, 32'h3014, 0, 0);
      drive(1, 32'h3018, 0, 1);
      chk("flush_out", {out_valid, out_pc, out_data}, {1'b0, 32'h3010, 128'h0});
      drive(0, 0, 1, 0, 2);
      chk("flush_drop", out_valid, 1'b0);
      // random stall/flush traffic
      pc = 32'h4000;
      for (int i = 0; i < 1000; i++) begin
         drive($urandom_range(3, 0) != 0, pc, $urandom_range(1, 0) != 0, $urandom_range(39, 0) == 0);
         pc += 4;
      end
      // asynchronous reset while FULL
      drive(1, 32'h3100, 0, 0);
      drive(1, 32'h3104, 0, 0);
      chk("pre_rst_full", in_ready, 1'b0);
      reset = 1'b1;
      #1;
      chk("async_rst", {out_valid, in_ready, out_pc, out_data}, {1'b0, 1'b1, 32'h3000, 128'h0});
      drive(0, 0, 0, 0, 2);
      reset = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
      drive(1, 32'h3200, 0, 0);
      drive(0, 0, 0, 0, 5);
      drive(0, 0, 1, 0, 3);
      chk("stat_stall_dir", stat_stall, 32'd5);
      chk("stat_bubble_dir", stat_bubble, 32'd3);
      drive(0, 0, 1, 1);
      chk("stat_keep", stat_stall, 32'd5);
`endif
      drive(0, 0, 1, 0, 3);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, successor to the fixed per-stage registers (F/D, D/E, E/M, M/W) of the five-stage MIPS core. It carries one PC plus an arbitrary-width payload between two stages with a valid/ready handshake. A 2-entry skid buffer gives full throughput with registered back-pressure, and a flush input turns the stage into a bubble. One instance per stage boundary, with the payload width set per boundary.

## Interface
Parameters:
- DATA_W, 128, payload width in bits (D/E: Instr, EXTout, Rsout, Rtout = 4×32)
- PC_W, 32, PC width
- RESET_PC, 32'h0000_3000, value of out_pc after reset and while empty

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  synchronous; discards all held and incoming beats
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat; registered, not a function of out_ready
- in_pc  in  PC_W  upstream PC
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  stage holds a beat for downstream
- out_ready  in  1  downstream accepts (0 = stall)
- out_pc  out  PC_W  PC of the head beat
- out_data  out  DATA_W  payload of the head beat; all-zero (nop) when out_valid=0
- stat_stall  out  32  stall-cycle count (only with PIPE_STAGE_STATS_EN)
- stat_bubble  out  32  bubble-cycle count (only with PIPE_STAGE_STATS_EN)

## Operation
- Storage: a main entry (drives the outputs) and a skid entry. Each entry holds pc and data.
- Handshake:
  - Accept when in_valid && in_ready.
  - Fire when out_valid && out_ready.
  - Beats leave in arrival order. No beat is duplicated or dropped, except on flush.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main valid, in_ready=1.
  - FULL: main and skid valid, in_ready=0.
- Transitions:
  - EMPTY: accept → ONE, main<=in.
  - ONE: accept && fire → ONE, main<=in.
  - ONE: accept && !fire → FULL, skid<=in.
  - ONE: !accept && fire → EMPTY.
  - FULL: fire → ONE, main<=skid.
  - FULL: !fire → hold.
- Flush:
  - Highest priority over every transition. The next state is EMPTY.
  - A beat offered in the flush cycle is discarded, even though in_ready may read 1.
  - out_pc keeps the PC of the flushed main entry, so downstream bubbles still carry an in-order PC. It is RESET_PC only if nothing has been accepted since reset.
- Bubble output: whenever out_valid=0, out_data is forced to 0 (sll $0,$0,0).
- Reset value (also applied on reset mid-operation, with no clock edge needed):
  - State EMPTY.
  - out_valid=0, in_ready=1.
  - out_pc=RESET_PC, out_data=0, skid contents=0.
  - Counters=0.

## Timing
- Latency: a beat accepted at edge N appears on out_* after edge N (1 cycle).
- Throughput: 1 beat/cycle sustained while out_ready=1.
- in_ready is a flop output: it falls one cycle after the first unaccepted fire, and rises the cycle after FULL drains.
- out_valid, out_pc and out_data are flop outputs. Only the out_data zero-gating is combinational, on out_valid.
- Simultaneous accept and fire in ONE: the new beat replaces the departing one with no bubble.
- flush together with reset: reset wins.

## Configuration
- PIPE_STAGE_STATS_EN defined:
  - stat_stall counts cycles with out_valid && !out_ready.
  - stat_bubble counts cycles with !out_valid.
  - Both counters saturate at 32'hFFFF_FFFF. Both are cleared by reset only, not by flush.
- Not defined: the stat ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package pipe_pkg:
  - state enum (EMPTY/ONE/FULL)
  - default RESET_PC constant 32'h0000_3000
  - NOP_INSTR constant 32'h0000_0000
- Sub-module pipe_stage_entry: a PC_W+DATA_W load-enable register with async clear. It is instantiated twice (main, skid).
- Control FSM and stats stay in the top module.

## Test plan
- Reset: assert reset mid-stream with FULL state → immediately out_valid=0, in_ready=1, out_pc=0x3000, out_data=0.
- Streaming: in_valid=1, out_ready=1, PCs 0x3000, 0x3004, 0x3008 → out_pc follows 1 cycle later, back-to-back, no bubbles.
- Stall and drain:
  - Send 0x3000, 0x3004 with out_ready=0 → in_ready=0 after the second accept.
  - Raise out_ready → outputs 0x3000 then 0x3004, with in_ready=1 the cycle after the second fire.
- Flush: state FULL (0x3010, 0x3014), flush=1 with in_valid=1 pc=0x3018 → next cycle out_valid=0, out_data=0, out_pc=0x3010; 0x3018 never appears.
- Stall–flush ordering: out_ready toggled randomly for 1000 cycles against a reference queue → identical output PC/data sequence.
- Stats (PIPE_STAGE_STATS_EN): 5 stall cycles, then 3 empty cycles → stat_stall=5, stat_bubble=3; a flush does not clear them.
